aes128_sbox_scheduler: RTL and testbench

Shares one pipelined AES S-box between two requesters: the round datapath (16 state bytes per round) and the key schedule (4 bytes per round). It arbitrates between the two byte streams and drives the S-box input, which feeds the front basis change. It tracks which requester owns every byte in flight and routes each S-box result back to its owner with the original byte index. Together with the S-box it forms the complete SubBytes/SubWord resource of the AES-128 core.

---
 rtl/aes128_sbox_scheduler.sv | 107 ++++++++++
 tb/tb_aes128_sbox_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_sbox_scheduler.sv
// Shares one pipelined AES S-box between the round datapath and the key schedule.
// Optional: define SBOX_SCHED_ROUND_ROBIN_EN for round-robin arbitration on contention.
module aes128_sbox_scheduler #(
  parameter int LATENCY = 3
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_st_valid,
  input  logic [7:0] in_st_byte,
  input  logic [3:0] in_st_idx,
  output logic       out_st_ready,
  input  logic       in_ks_valid,
  input  logic [7:0] in_ks_byte,
  input  logic [1:0] in_ks_idx,
  output logic       out_ks_ready,
  output logic       out_sb_valid,
  output logic [7:0] out_sb_byte,
  input  logic [7:0] in_sb_byte,
  output logic       out_st_res_valid,
  output logic [7:0] out_st_res_byte,
  output logic [3:0] out_st_res_idx,
  output logic       out_ks_res_valid,
  output logic [7:0] out_ks_res_byte,
  output logic [1:0] out_ks_res_idx,
  output logic       out_idle
);

  logic st_ready, ks_ready, st_hs, ks_hs;

`ifdef SBOX_SCHED_ROUND_ROBIN_EN
  // rr_ptr = 1 means the state stream wins the next contested cycle
  logic rr_ptr;

  always_comb begin
    ks_ready = !in_reset && in_ks_valid && !(in_st_valid && rr_ptr);
    st_ready = !in_reset && in_st_valid && (!in_ks_valid || rr_ptr);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset)
      rr_ptr <= 1'b0;
    else if (in_ks_valid && in_st_valid)
      rr_ptr <= ~rr_ptr;
  end
`else
  always_comb begin
    ks_ready = !in_reset && in_ks_valid;
    st_ready = !in_reset && in_st_valid && !in_ks_valid;
  end
`endif

  assign st_hs        = in_st_valid && st_ready;
  assign ks_hs        = in_ks_valid && ks_ready;
  assign out_st_ready = st_ready;
  assign out_ks_ready = ks_ready;
  assign out_sb_valid = st_hs || ks_hs;
  assign out_sb_byte  = ks_hs ? in_ks_byte : (st_hs ? in_st_byte : 8'h00);

  // Tag pipeline mirrors the S-box depth; owner 1 = key schedule
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_own;
  logic [3:0]         tag_idx [LATENCY];

  always_ff @(posedge in_clock) begin
    tag_own[0] <= ks_hs;
    tag_idx[0] <= ks_hs ? {2'b00, in_ks_idx} : in_st_idx;
    for (int i = 1; i < LATENCY; i++) begin
      tag_own[i] <= tag_own[i-1];
      tag_idx[i] <= tag_idx[i-1];
    end
    if (in_reset) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= st_hs || ks_hs;
      for (int i = 1; i < LATENCY; i++)
        tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      out_st_res_valid <= 1'b0;
      out_st_res_byte  <= 8'h00;
      out_st_res_idx   <= 4'h0;
      out_ks_res_valid <= 1'b0;
      out_ks_res_byte  <= 8'h00;
      out_ks_res_idx   <= 2'h0;
    end else begin
      out_st_res_valid <= 1'b0;
      out_ks_res_valid <= 1'b0;
      if (tag_v[LATENCY-1]) begin
        if (tag_own[LATENCY-1]) begin
          out_ks_res_valid <= 1'b1;
          out_ks_res_byte  <= in_sb_byte;
          out_ks_res_idx   <= tag_idx[LATENCY-1][1:0];
        end else begin
          out_st_res_valid <= 1'b1;
          out_st_res_byte  <= in_sb_byte;
          out_st_res_idx   <= tag_idx[LATENCY-1];
        end
      end
    end
  end

  assign out_idle = !(st_hs || ks_hs) && !(|tag_v) && !out_st_res_valid && !out_ks_res_valid;

endmodule

// File: tb/tb_aes128_sbox_scheduler.sv
// Self-checking bench for aes128_sbox_scheduler: queue-based result model plus directed literal checks.
// Override LAT (1..8) to test other S-box depths; define SBOX_SCHED_ROUND_ROBIN_EN for round-robin.
module tb_aes128_sbox_scheduler #(parameter int LAT = 3);

  logic       in_clock = 1'b0;
  logic       in_reset = 1'b1;
  logic       in_st_valid = 1'b0;
  logic [7:0] in_st_byte = 8'h00;
  logic [3:0] in_st_idx = 4'h0;
  logic       out_st_ready;
  logic       in_ks_valid = 1'b0;
  logic [7:0] in_ks_byte = 8'h00;
  logic [1:0] in_ks_idx = 2'h0;
  logic       out_ks_ready;
  logic       out_sb_valid;
  logic [7:0] out_sb_byte;
  logic [7:0] in_sb_byte = 8'h00;
  logic       out_st_res_valid;
  logic [7:0] out_st_res_byte;
  logic [3:0] out_st_res_idx;
  logic       out_ks_res_valid;
  logic [7:0] out_ks_res_byte;
  logic [1:0] out_ks_res_idx;
  logic       out_idle;

  aes128_sbox_scheduler #(.LATENCY(LAT)) dut (
    .in_clock(in_clock), .in_reset(in_reset),
    .in_st_valid(in_st_valid), .in_st_byte(in_st_byte), .in_st_idx(in_st_idx),
    .out_st_ready(out_st_ready),
    .in_ks_valid(in_ks_valid), .in_ks_byte(in_ks_byte), .in_ks_idx(in_ks_idx),
    .out_ks_ready(out_ks_ready),
    .out_sb_valid(out_sb_valid), .out_sb_byte(out_sb_byte), .in_sb_byte(in_sb_byte),
    .out_st_res_valid(out_st_res_valid), .out_st_res_byte(out_st_res_byte),
    .out_st_res_idx(out_st_res_idx),
    .out_ks_res_valid(out_ks_res_valid), .out_ks_res_byte(out_ks_res_byte),
    .out_ks_res_idx(out_ks_res_idx),
    .out_idle(out_idle)
  );

  always #5 in_clock = ~in_clock;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int ks_gnt_cnt = 0, st_gnt_cnt = 0, ks_res_cnt = 0, st_res_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Stand-in S-box: pinned 8'h53 -> 8'hED, otherwise a nibble swap xor 8'h63
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    if (x == 8'h53) return 8'hED;
    return {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // S-box environment: in cycle k present f(byte issued in cycle k-LAT)
  logic [7:0] sbq [9];
  initial for (int i = 0; i < 9; i++) sbq[i] = 8'h00;
  always @(negedge in_clock) begin
    for (int i = 8; i > 0; i--) sbq[i] = sbq[i-1];
    sbq[0] = out_sb_byte;
    in_sb_byte = sbox_f(sbq[LAT]);
  end

  typedef struct {
    int         due;
    bit         own;
    logic [3:0] idx;
    logic [7:0] b;
  } exp_t;
  exp_t q[$];
  bit prev_rst = 1'b1;
  bit rr_state_first = 1'b0;

  // Model: arbitration from the rules, each grant expects its result LAT+1 cycles later
  always @(negedge in_clock) begin
    bit ek, es, exp_idle;
    exp_t e;
    cyc++;
    ek = 1'b0;
    es = 1'b0;
    if (!in_reset) begin
      if (in_ks_valid && in_st_valid) begin
`ifdef SBOX_SCHED_ROUND_ROBIN_EN
        ek = !rr_state_first;
        es = rr_state_first;
`else
        ek = 1'b1;
`endif
      end else begin
        ek = in_ks_valid;
        es = in_st_valid;
      end
    end
    chk("ks_ready", 32'(out_ks_ready), 32'(ek));
    chk("st_ready", 32'(out_st_ready), 32'(es));
    chk("sb_valid", 32'(out_sb_valid), 32'(ek || es));
    chk("sb_byte", 32'(out_sb_byte), ek ? 32'(in_ks_byte) : (es ? 32'(in_st_byte) : 32'h0));
    if (out_ks_ready) ks_gnt_cnt++;
    if (out_st_ready) st_gnt_cnt++;
    if (out_ks_res_valid) ks_res_cnt++;
    if (out_st_res_valid) st_res_cnt++;

    if (in_reset) begin
      if (prev_rst) begin
        chk("idle_rst", 32'(out_idle), 32'h1);
        chk("st_res_valid_rst", 32'(out_st_res_valid), 32'h0);
        chk("ks_res_valid_rst", 32'(out_ks_res_valid), 32'h0);
      end
      q.delete();
      rr_state_first = 1'b0;
    end else begin
      exp_idle = !(ek || es) && (q.size() == 0);
      chk("idle", 32'(out_idle), 32'(exp_idle));
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("ks_res_valid", 32'(out_ks_res_valid), 32'(e.own));
        chk("st_res_valid", 32'(out_st_res_valid), 32'(!e.own));
        if (e.own) begin
          chk("ks_res_byte", 32'(out_ks_res_byte), 32'(e.b));
          chk("ks_res_idx", 32'(out_ks_res_idx), 32'(e.idx[1:0]));
        end else begin
          chk("st_res_byte", 32'(out_st_res_byte), 32'(e.b));
          chk("st_res_idx", 32'(out_st_res_idx), 32'(e.idx));
        end
      end else begin
        chk("ks_res_valid", 32'(out_ks_res_valid), 32'h0);
        chk("st_res_valid", 32'(out_st_res_valid), 32'h0);
      end
      if (ek) q.push_back('{cyc + LAT + 1, 1'b1, {2'b00, in_ks_idx}, sbox_f(in_ks_byte)});
      if (es) q.push_back('{cyc + LAT + 1, 1'b0, in_st_idx, sbox_f(in_st_byte)});
      if (in_ks_valid && in_st_valid) rr_state_first = !rr_state_first;
    end
    prev_rst = in_reset;
  end

  task automatic step();
    @(posedge in_clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_st_valid = 1'b0;
    in_ks_valid = 1'b0;
  endtask

  // One state byte; literal check of exact result cycle, byte and index
  task automatic single_st(input logic [7:0] b, input logic [3:0] idx, input logic [7:0] rb);
    in_st_valid = 1'b1; in_st_byte = b; in_st_idx = idx;
    @(negedge in_clock);
    chk("single_grant", 32'(out_st_ready), 32'h1);
    step();
    idle_inputs();
    for (int j = 1; j <= LAT + 1; j++) begin
      @(negedge in_clock);
      chk("single_res_timing", 32'(out_st_res_valid), 32'(j == LAT + 1));
      chk("single_ks_quiet", 32'(out_ks_res_valid), 32'h0);
      if (j == LAT + 1) begin
        chk("single_res_byte", 32'(out_st_res_byte), 32'(rb));
        chk("single_res_idx", 32'(out_st_res_idx), 32'(idx));
      end
    end
    step();
  endtask

  logic [11:0] mix_ks, mix_st;
  int base_ks, base_st, base_res;

  initial begin
    // Reset for a few cycles, then 20 idle cycles
    in_reset = 1'b1;
    repeat (3) step();
    in_reset = 1'b0;
    base_res = st_res_cnt + ks_res_cnt;
    repeat (20) step();
    chk("idle_no_results", 32'(st_res_cnt + ks_res_cnt - base_res), 32'h0);

    single_st(8'h53, 4'd5, 8'hED);

    // 16 back-to-back state bytes
    base_res = st_res_cnt;
    for (int i = 0; i < 16; i++) begin
      in_st_valid = 1'b1; in_st_byte = 8'(i); in_st_idx = 4'(i);
      step();
    end
    idle_inputs();
    repeat (LAT + 3) step();
    chk("burst16_count", 32'(st_res_cnt - base_res), 32'd16);

    // Contention for 8 cycles
    base_ks = ks_gnt_cnt; base_st = st_gnt_cnt;
    for (int i = 0; i < 8; i++) begin
      in_ks_valid = 1'b1; in_ks_byte = 8'hA0 + 8'(i); in_ks_idx = 2'(i);
      in_st_valid = 1'b1; in_st_byte = 8'h40 + 8'(i); in_st_idx = 4'(i);
      step();
    end
    idle_inputs();
`ifdef SBOX_SCHED_ROUND_ROBIN_EN
    chk("contest_ks_grants", 32'(ks_gnt_cnt - base_ks), 32'd4);
    chk("contest_st_grants", 32'(st_gnt_cnt - base_st), 32'd4);
`else
    chk("contest_ks_grants", 32'(ks_gnt_cnt - base_ks), 32'd8);
    chk("contest_st_grants", 32'(st_gnt_cnt - base_st), 32'd0);
`endif
    repeat (LAT + 3) step();

    // Reset with 3 bytes in flight; state valid held to show ready forced low
    for (int i = 0; i < 3; i++) begin
      in_st_valid = 1'b1; in_st_byte = 8'h70 + 8'(i); in_st_idx = 4'(9 + i);
      step();
    end
    in_reset = 1'b1;
    step();
    in_reset = 1'b0;
    idle_inputs();
    base_res = st_res_cnt + ks_res_cnt;
    repeat (LAT + 2) step();
    chk("flush_no_results", 32'(st_res_cnt + ks_res_cnt - base_res), 32'h0);
    single_st(8'h3C, 4'd14, 8'hA0);

    // Mixed key/state pattern
    mix_ks = 12'b0111_0100_1101;
    mix_st = 12'b1110_0111_0110;
    base_res = st_res_cnt + ks_res_cnt;
    for (int i = 0; i < 12; i++) begin
      in_ks_valid = mix_ks[i]; in_ks_byte = 8'hC0 + 8'(i); in_ks_idx = 2'(i);
      in_st_valid = mix_st[i]; in_st_byte = 8'h20 + 8'(i); in_st_idx = 4'(i);
      step();
    end
    idle_inputs();
    repeat (LAT + 4) step();
    chk("drained_idle", 32'(out_idle), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
